// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//   Host-to-device PS/2 command transmitter. It inhibits the bus by holding
//   the clock low, issues a request-to-send (data low, clock released), and
//   then shifts out one command byte. Each data bit is presented on the
//   device-generated falling clock edges. The bit order is LSB first, with
//   an odd parity bit and a stop bit. Finally it checks the device
//   acknowledge bit and waits for both lines to return idle.
//
//   Ports
//     clk         system clock, rising edge
//     reset       asynchronous, active-high
//     send        start request, honoured only when idle
//     tx_data     command byte to transmit
//     ps2_clk_in  raw PS/2 clock line level (asynchronous)
//     ps2_dat_in  raw PS/2 data line level (asynchronous)
//     ps2_clk_oe  1 = pull PS2_CLK low, 0 = release
//     ps2_dat_oe  1 = pull PS2_DAT low, 0 = release
//     busy        transfer in progress
//     done        one-cycle pulse: acknowledged, bus idle again
//     error       one-cycle pulse: NACK or device timeout
// ---------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int SETUP_CYCLES   = 250,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int PH_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FL_W   = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE} state_t;

  // Line synchronizers and clock glitch filter
  logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic            r_clk_flt, r_fall;
  logic [FL_W-1:0] r_flt_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_s1  <= 1'b1;
      r_clk_s2  <= 1'b1;
      r_dat_s1  <= 1'b1;
      r_dat_s2  <= 1'b1;
      r_clk_flt <= 1'b1;
      r_fall    <= 1'b0;
      r_flt_cnt <= '0;
    end else begin
      r_clk_s1 <= ps2_clk_in;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_dat_in;
      r_dat_s2 <= r_dat_s1;
      r_fall   <= 1'b0;
      // Any sample that agrees with the filtered level restarts the run.
      if (r_clk_s2 == r_clk_flt) begin
        r_flt_cnt <= '0;
      end else if (r_flt_cnt == FL_W'(FILTER_LEN - 1)) begin
        r_clk_flt <= r_clk_s2;
        r_flt_cnt <= '0;
        r_fall    <= r_clk_flt;   // strobe only when leaving 1
      end else begin
        r_flt_cnt <= r_flt_cnt + FL_W'(1);
      end
    end
  end

  // Transfer FSM
  state_t          r_state, w_state_nx;
  logic [10:0]     r_frame, w_frame_nx;
  logic [3:0]      r_idx, w_idx_nx, w_idx_inc;
  logic [PH_W-1:0] r_ph_cnt, w_ph_nx;
  logic [TO_W-1:0] r_to_cnt, w_to_nx;
  logic            r_clk_oe, r_dat_oe, r_busy, r_done, r_error;
  logic            w_clk_oe_nx, w_dat_oe_nx, w_busy_nx, w_done_nx, w_error_nx;
  logic            w_to_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_frame  <= '0;
      r_idx    <= '0;
      r_ph_cnt <= '0;
      r_to_cnt <= '0;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_frame  <= w_frame_nx;
      r_idx    <= w_idx_nx;
      r_ph_cnt <= w_ph_nx;
      r_to_cnt <= w_to_nx;
      r_clk_oe <= w_clk_oe_nx;
      r_dat_oe <= w_dat_oe_nx;
      r_busy   <= w_busy_nx;
      r_done   <= w_done_nx;
      r_error  <= w_error_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_frame_nx  = r_frame;
    w_idx_nx    = r_idx;
    w_ph_nx     = r_ph_cnt;
    w_to_nx     = r_to_cnt;
    w_clk_oe_nx = r_clk_oe;
    w_dat_oe_nx = r_dat_oe;
    w_busy_nx   = r_busy;
    w_done_nx   = 1'b0;
    w_error_nx  = 1'b0;
    w_idx_inc   = r_idx + 4'd1;
    // The timeout counter holds the cycles elapsed since the last device
    // edge (edge cycle included), so the error lands TIMEOUT_CYCLES after it.
    w_to_hit    = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) && !r_fall;

    case (r_state)
      IDLE: begin
        w_clk_oe_nx = 1'b0;
        w_dat_oe_nx = 1'b0;
        w_busy_nx   = 1'b0;
        if (send) begin
          // {stop, odd parity, data, start}
          w_frame_nx  = {1'b1, ~^tx_data, tx_data, 1'b0};
          w_state_nx  = INHIBIT;
          w_busy_nx   = 1'b1;
          w_clk_oe_nx = 1'b1;
          w_ph_nx     = '0;
        end
      end
      INHIBIT: begin
        if (r_ph_cnt == PH_W'(INHIBIT_CYCLES - 1)) begin
          w_state_nx  = START;
          w_dat_oe_nx = 1'b1;
          w_ph_nx     = '0;
        end else begin
          w_ph_nx = r_ph_cnt + PH_W'(1);
        end
      end
      START: begin
        if (r_ph_cnt == PH_W'(SETUP_CYCLES - 1)) begin
          w_state_nx  = SHIFT;
          w_clk_oe_nx = 1'b0;
          w_idx_nx    = '0;
          w_to_nx     = '0;
          w_ph_nx     = '0;
        end else begin
          w_ph_nx = r_ph_cnt + PH_W'(1);
        end
      end
      SHIFT: begin
        if (r_fall) begin
          // Edge n presents frame bit n; the start bit is already on the line.
          w_idx_nx    = w_idx_inc;
          w_dat_oe_nx = ~r_frame[w_idx_inc];
          w_to_nx     = TO_W'(1);
          if (r_idx == 4'd9) w_state_nx = ACK;
        end else begin
          w_to_nx = r_to_cnt + TO_W'(1);
        end
      end
      ACK: begin
        if (r_fall) begin
          w_to_nx = TO_W'(1);
          if (!r_dat_s2) begin
            w_state_nx = WAIT_IDLE;
          end else begin
            w_state_nx = IDLE;
            w_error_nx = 1'b1;
            w_busy_nx  = 1'b0;
          end
        end else begin
          w_to_nx = r_to_cnt + TO_W'(1);
        end
      end
      WAIT_IDLE: begin
        if (r_clk_flt && r_dat_s2) begin
          w_state_nx = IDLE;
          w_done_nx  = 1'b1;
          w_busy_nx  = 1'b0;
        end else if (r_fall) begin
          w_to_nx = TO_W'(1);
        end else begin
          w_to_nx = r_to_cnt + TO_W'(1);
        end
      end
      default: w_state_nx = IDLE;
    endcase

    // Device went silent: abandon the transfer and free both lines.
    if ((r_state == SHIFT || r_state == ACK || r_state == WAIT_IDLE) &&
        w_to_hit && !w_done_nx && !w_error_nx) begin
      w_state_nx  = IDLE;
      w_error_nx  = 1'b1;
      w_busy_nx   = 1'b0;
      w_clk_oe_nx = 1'b0;
      w_dat_oe_nx = 1'b0;
      w_to_nx     = '0;
    end
  end

  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = r_dat_oe;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH = 5000;
  localparam int SET = 250;
  localparam int TO  = 1500;
  localparam int FL  = 8;
  localparam int HP  = 20;   // device half period in clk cycles

  logic       clk = 1'b0;
  logic       reset;
  logic       send;
  logic [7:0] tx_data;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       busy, done, error;
  logic       dev_clk, dev_dat;

  int checks = 0;
  int errors = 0;
  int n_done, n_err, n_both, n_busybad;

  always #5 clk = ~clk;

  // Open-drain bus: either side can pull a line low.
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .SETUP_CYCLES  (SET),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN    (FL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .send      (send),
    .tx_data   (tx_data),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  // Pulse monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (done)                n_done++;
      if (error)               n_err++;
      if (done && error)       n_both++;
      if ((done || error) && busy) n_busybad++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected line values seen by the device on rising edges 1..10:
  // eight data bits LSB first, odd parity bit, stop bit.
  function automatic logic [9:0] frame_model(input logic [7:0] d);
    logic [9:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i] = (d >> i) & 1;
      ones += (d >> i) & 1;
    end
    f[8] = (ones % 2 == 0) ? 1'b1 : 1'b0;
    f[9] = 1'b1;
    return f;
  endfunction

  task automatic clear_mon();
    n_done = 0; n_err = 0; n_both = 0; n_busybad = 0;
  endtask

  // Request a send and time the inhibit and request-to-send phases.
  task automatic start_phases(input logic [7:0] d, input string tag);
    int n;
    @(negedge clk); tx_data = d; send = 1'b1;
    @(negedge clk); send = 1'b0; tx_data = 8'($urandom);
    chk({tag, "_busy_on"}, busy, 1);
    n = 0;
    while (ps2_clk_oe && !ps2_dat_oe && n < INH + 100) begin n++; @(negedge clk); end
    chk({tag, "_inhibit_len"}, n, INH);
    n = 0;
    while (ps2_clk_oe && ps2_dat_oe && n < SET + 100) begin n++; @(negedge clk); end
    chk({tag, "_setup_len"}, n, SET);
    chk({tag, "_start_bit"}, {ps2_clk_oe, ps2_dat_oe}, 2'b01);
  endtask

  task automatic run_txn(input logic [7:0] d, input bit nack, input bit glitch,
                         input bit poke, input bit exp_par, input string tag);
    logic [9:0] got, exp;
    int n;
    exp = frame_model(d);
    got = '0;
    clear_mon();
    start_phases(d, tag);
    for (int e = 1; e <= 11; e++) begin
      if (glitch && e == 5) begin
        wait_cyc(5); dev_clk = 1'b0; wait_cyc(3); dev_clk = 1'b1; wait_cyc(HP - 8);
      end else if (e == 11) begin
        wait_cyc(HP / 2); dev_dat = nack; wait_cyc(HP - HP / 2);
      end else begin
        wait_cyc(HP);
      end
      dev_clk = 1'b0;
      if (poke && e == 3) begin
        send = 1'b1; tx_data = ~d; wait_cyc(1); send = 1'b0; wait_cyc(HP - 1);
      end else begin
        wait_cyc(HP);
      end
      if (e <= 10) got[e-1] = ps2_dat_in;
      dev_clk = 1'b1;
      if (e == 11) dev_dat = 1'b1;
    end
    n = 0;
    while (n_done == 0 && n_err == 0 && n < 400) begin n++; @(negedge clk); end
    wait_cyc(30);
    chk({tag, "_frame"}, got, exp);
    chk({tag, "_parity"}, got[8], exp_par);
    chk({tag, "_done_cnt"}, n_done, nack ? 0 : 1);
    chk({tag, "_err_cnt"}, n_err, nack ? 1 : 0);
    chk({tag, "_overlap"}, n_both + n_busybad, 0);
    chk({tag, "_idle_after"}, {busy, ps2_clk_oe, ps2_dat_oe}, 3'b000);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         nack;
    bit         glitch;
    bit         poke;
    bit         exp_par;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;
    logic [7:0] rd;
    vecs[0] = '{8'hED, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'h07, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'h01, 1'b0, 1'b0, 1'b1, 1'b0};

    reset = 1'b1; send = 1'b0; tx_data = 8'h00; dev_clk = 1'b1; dev_dat = 1'b1;
    clear_mon();
    wait_cyc(5);
    chk("reset_state", {ps2_clk_oe, ps2_dat_oe, busy, done, error}, 5'b00000);
    @(negedge clk); reset = 1'b0;
    wait_cyc(20);

    // Table-driven transfers
    for (int i = 0; i < 5; i++)
      run_txn(vecs[i].data, vecs[i].nack, vecs[i].glitch, vecs[i].poke,
              vecs[i].exp_par, $sformatf("vec%0d", i));

    // Randomized transfers checked against the frame model
    for (int i = 0; i < 2; i++) begin
      logic [9:0] f;
      rd = 8'($urandom);
      f = frame_model(rd);
      run_txn(rd, ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), f[8],
              $sformatf("rnd%0d", i));
    end

    // Device goes silent after edge 4
    clear_mon();
    start_phases(8'h5A, "tmo");
    for (int e = 1; e <= 3; e++) begin
      wait_cyc(HP); dev_clk = 1'b0; wait_cyc(HP); dev_clk = 1'b1;
    end
    wait_cyc(HP);
    dev_clk = 1'b0;
    n = 0;
    while (!error && n < 2 + FL + TO + 50) begin
      @(negedge clk); n++;
      if (n == HP) dev_clk = 1'b1;
    end
    chk("tmo_latency", n, 2 + FL + TO);
    chk("tmo_oe_released", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    wait_cyc(30);
    chk("tmo_counts", {n_done[7:0], n_err[7:0]}, {8'd0, 8'd1});
    chk("tmo_busy_after", busy, 0);

    // Reset in the middle of the request-to-send phase
    @(negedge clk); tx_data = 8'hC3; send = 1'b1;
    @(negedge clk); send = 1'b0;
    n = 0;
    while (!ps2_dat_oe && n < INH + 100) begin n++; @(negedge clk); end
    chk("rst_reached_start", {ps2_clk_oe, ps2_dat_oe}, 2'b11);
    wait_cyc(10);
    #2 reset = 1'b1;
    #1 chk("rst_async_release", {ps2_clk_oe, ps2_dat_oe, busy}, 3'b000);
    wait_cyc(3);
    reset = 1'b0;
    clear_mon();
    wait_cyc(50);
    chk("rst_no_pulse", n_done + n_err, 0);
    run_txn(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, "rst_fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL provide parameter INHIBIT_CYCLES, default 5000, meaning clk cycles the PS/2 clock is held low before the start bit (100 us at 50 MHz).
REQ-002 SHALL provide parameter SETUP_CYCLES, default 250, meaning clk cycles data is held low with clock still low before the clock is released.
REQ-003 SHALL provide parameter TIMEOUT_CYCLES, default 750000, meaning the maximum clk cycles allowed between device events (15 ms).
REQ-004 SHALL provide parameter FILTER_LEN, default 8, meaning the number of consecutive equal synchronized samples needed to change the filtered PS/2 clock.
REQ-005 clk  input  1  system clock (50 MHz); all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 send  input  1  request to transmit tx_data; sampled only in IDLE.
REQ-008 tx_data  input  8  command byte, sent LSB first.
REQ-009 ps2_clk_in  input  1  raw PS/2 clock line level (asynchronous).
REQ-010 ps2_dat_in  input  1  raw PS/2 data line level (asynchronous).
REQ-011 ps2_clk_oe  output  1  1 = top level drives PS2_CLK low; 0 = released (high-Z).
REQ-012 ps2_dat_oe  output  1  1 = top level drives PS2_DAT low; 0 = released.
REQ-013 busy  output  1  high from the cycle after send is accepted until the cycle done or error pulses.
REQ-014 done  output  1  one-cycle pulse: device acknowledged and both lines are idle.
REQ-015 error  output  1  one-cycle pulse: NACK (ack sampled high) or timeout.

Function
REQ-016 ps2_clk_in and ps2_dat_in SHALL each pass through a 2-flop synchronizer; the filtered clock SHALL go 0 after FILTER_LEN consecutive synchronized 0s and go 1 after FILTER_LEN consecutive 1s; a falling edge is the filtered 1->0 transition, as a one-cycle strobe.
REQ-017 States SHALL be IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE.
REQ-018 IDLE: oe outputs 0, busy 0; send=1 latches tx_data and odd parity (~^tx_data) into an 11-bit frame, next state INHIBIT; send while busy is ignored.
REQ-019 INHIBIT: ps2_clk_oe=1, ps2_dat_oe=0 for exactly INHIBIT_CYCLES cycles, then START.
REQ-020 START: ps2_clk_oe=1, ps2_dat_oe=1 (start bit 0) for exactly SETUP_CYCLES cycles, then ps2_clk_oe=0 and SHIFT with bit index 0.
REQ-021 SHIFT: on falling edges 1..8 ps2_dat_oe SHALL equal ~tx_data[index]; on edge 9 ~parity; on edge 10 ps2_dat_oe=0 (stop bit), next state ACK; the ps2_dat_oe update SHALL occur the cycle after the edge strobe.
REQ-022 ACK: on the next falling edge, synchronized data 0 -> WAIT_IDLE; data 1 -> error pulse, IDLE.
REQ-023 WAIT_IDLE: when filtered clock and synchronized data are both 1, done SHALL pulse the following cycle and the state SHALL return to IDLE.
REQ-024 A timeout counter SHALL clear on entry to SHIFT and on every falling edge; if it reaches TIMEOUT_CYCLES in SHIFT, ACK or WAIT_IDLE, error SHALL pulse one cycle, both oe outputs 0, and the state SHALL return to IDLE.
REQ-025 done and error SHALL never assert in the same cycle; busy SHALL drop in the same cycle as the done/error pulse.
REQ-026 Counters SHALL be sized for the parameter values without wrap; the bit index SHALL be 4 bits, counting 0..10.

Reset
REQ-027 reset=1 SHALL immediately force IDLE, ps2_clk_oe=0, ps2_dat_oe=0, busy=0, done=0, error=0, synchronizers and filter=1, counters=0.
REQ-028 Reset asserted mid-transmission SHALL release both lines combinationally with respect to clk, and no done/error pulse SHALL follow its deassertion.

Verification
REQ-029 send with tx_data=0xED, device model ACKs -> clk_oe high 5000 cycles, dat_oe high, data bits 1,0,1,1,0,1,1,1, parity 1, stop released, done pulses once, busy low after.
REQ-030 tx_data=0x07 -> parity bit 0 on line at edge 9; done pulses.
REQ-031 Device leaves data high at ACK edge -> error pulses 1 cycle, done stays 0, state IDLE.
REQ-032 Device stops clocking after edge 4 -> error exactly TIMEOUT_CYCLES after edge 4, both oe 0.
REQ-033 Glitch of 3 cycles low on ps2_clk_in in SHIFT -> no edge counted, bit index unchanged.
REQ-034 Reset pulsed during START -> both oe 0 immediately; send after release starts a fresh INHIBIT of 5000 cycles.
